// File: rtl/bram18_sdp_rd_arbiter.sv
// rtl/bram18_sdp_rd_arbiter.sv - RAMB18E2 SDP x18 controller: round-robin read port A, write port B.
// Optional power-up zero fill of the array is enabled by defining BRAM18_ARB_INIT_CLEAR_EN.
module bram18_sdp_rd_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              rd0_valid_i,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  output logic              rd0_ready_o,
  output logic              rd0_rvalid_o,
  output logic [DATA_W-1:0] rd0_rdata_o,
  input  logic              rd1_valid_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic              rd1_ready_o,
  output logic              rd1_rvalid_o,
  output logic [DATA_W-1:0] rd1_rdata_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              init_done_o,
  output logic [13:0]       bram_addrardaddr_o,
  output logic              bram_enarden_o,
  output logic              bram_regcearegce_o,
  input  logic [15:0]       bram_doutadout_i,
  input  logic [1:0]        bram_doutpadoutp_i,
  output logic [13:0]       bram_addrbwraddr_o,
  output logic              bram_enbwren_o,
  output logic [3:0]        bram_webwe_o,
  output logic [15:0]       bram_dinbdin_o,
  output logic [1:0]        bram_dinpbdinp_o
);

  logic              init_done;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef BRAM18_ARB_INIT_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    init_done  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_CLEAR;
      S_CLEAR: begin
        clr_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = S_DONE;
      end
      S_DONE:  init_done = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign clr_addr = clr_addr_q;
`else
  logic init_done_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) init_done_q <= 1'b0;
    else         init_done_q <= 1'b1;
  end

  assign init_done = init_done_q;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
`endif

  // Round-robin with a lock: a grant that was not accepted is held until it completes.
  logic              last_q;
  logic              lock_q;
  logic              lock_id_q;
  logic              gnt_id;
  logic              gnt_vld;
  logic [ADDR_W-1:0] gnt_addr;
  logic              wr_hs;
  logic              collision;
  logic              rd_hs;

  always_comb begin
    gnt_id = 1'b0;
    if (lock_q)                          gnt_id = lock_id_q;
    else if (rd0_valid_i && rd1_valid_i) gnt_id = ~last_q;
    else if (rd1_valid_i)                gnt_id = 1'b1;
  end

  assign gnt_vld   = gnt_id ? rd1_valid_i : rd0_valid_i;
  assign gnt_addr  = gnt_id ? rd1_addr_i : rd0_addr_i;
  assign wr_hs     = wr_valid_i & init_done;
  assign collision = wr_hs & gnt_vld & (wr_addr_i == gnt_addr);
  assign rd_hs     = gnt_vld & init_done & ~collision;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else if (rd_hs) begin
      last_q <= gnt_id;
      lock_q <= 1'b0;
    end else if (gnt_vld) begin
      lock_q    <= 1'b1;
      lock_id_q <= gnt_id;
    end
  end

  logic [RD_LAT-1:0] tag_v_q;
  logic [RD_LAT-1:0] tag_id_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= rd_hs;
      tag_id_q[0] <= gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  // Output register load lines up with the array read one cycle after issue.
  generate
    if (RD_LAT >= 2) begin : g_regce
      assign bram_regcearegce_o = tag_v_q[RD_LAT-2];
    end else begin : g_no_regce
      assign bram_regcearegce_o = 1'b0;
    end
  endgenerate

  logic              rsp_v;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  assign rsp_v    = tag_v_q[RD_LAT-1];
  assign rsp_id   = tag_id_q[RD_LAT-1];
  assign rsp_data = {bram_doutpadoutp_i, bram_doutadout_i};

  assign rd0_ready_o  = rd_hs & ~gnt_id;
  assign rd1_ready_o  = rd_hs & gnt_id;
  assign rd0_rvalid_o = rsp_v & ~rsp_id;
  assign rd1_rvalid_o = rsp_v & rsp_id;
  assign rd0_rdata_o  = rd0_rvalid_o ? rsp_data : '0;
  assign rd1_rdata_o  = rd1_rvalid_o ? rsp_data : '0;

  assign bram_enarden_o     = rd_hs;
  assign bram_addrardaddr_o = rd_hs ? {gnt_addr, 4'b0000} : '0;

  assign wr_ready_o         = init_done;
  assign init_done_o        = init_done;
  assign bram_enbwren_o     = wr_hs | clr_we;
  assign bram_webwe_o       = bram_enbwren_o ? 4'b0011 : 4'b0000;
  assign bram_addrbwraddr_o = clr_we ? {clr_addr, 4'b0000} :
                              wr_hs  ? {wr_addr_i, 4'b0000} : '0;
  assign bram_dinbdin_o     = wr_hs ? wr_data_i[15:0] : '0;
  assign bram_dinpbdinp_o   = wr_hs ? wr_data_i[17:16] : '0;

endmodule

// File: tb/tb_bram18_sdp_rd_arbiter.sv
// tb/tb_bram18_sdp_rd_arbiter.sv - directed bench with RAMB18E2 SDP model and response scoreboard.
module tb_bram18_sdp_rd_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd0_valid = 1'b0, rd1_valid = 1'b0, wr_valid = 1'b0;
  logic [9:0]  rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [17:0] wr_data = '0;
  logic        rd0_ready, rd1_ready, rd0_rvalid, rd1_rvalid, wr_ready, init_done;
  logic [17:0] rd0_rdata, rd1_rdata;
  logic [13:0] a_addr, b_addr;
  logic        a_en, regce, b_en;
  logic [3:0]  b_we;
  logic [15:0] dout, din;
  logic [1:0]  doutp, dinp;

  always #5 clk = ~clk;

  bram18_sdp_rd_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .rd0_valid_i(rd0_valid), .rd0_addr_i(rd0_addr), .rd0_ready_o(rd0_ready),
    .rd0_rvalid_o(rd0_rvalid), .rd0_rdata_o(rd0_rdata),
    .rd1_valid_i(rd1_valid), .rd1_addr_i(rd1_addr), .rd1_ready_o(rd1_ready),
    .rd1_rvalid_o(rd1_rvalid), .rd1_rdata_o(rd1_rdata),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .init_done_o(init_done),
    .bram_addrardaddr_o(a_addr), .bram_enarden_o(a_en), .bram_regcearegce_o(regce),
    .bram_doutadout_i(dout), .bram_doutpadoutp_i(doutp),
    .bram_addrbwraddr_o(b_addr), .bram_enbwren_o(b_en), .bram_webwe_o(b_we),
    .bram_dinbdin_o(din), .bram_dinpbdinp_o(dinp)
  );

  // RAMB18E2 SDP x18 behaviour with DOA_REG=1
  logic [17:0] mem [0:1023];
  logic [17:0] lat_q = '0, dout_q = '0;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (b_en && b_we == 4'b0011) mem[b_addr[13:4]] <= {dinp, din};
    if (a_en) lat_q <= mem[a_addr[13:4]];
    if (regce) dout_q <= lat_q;
  end
  assign dout  = dout_q[15:0];
  assign doutp = dout_q[17:16];

  typedef struct packed { logic [17:0] d; int cyc; } exp_t;
  exp_t        q0[$], q1[$];
  logic [17:0] sh [0:1023];
  int          errors = 0, checks = 0, cyc = 0, rv0_cnt = 0, rv1_cnt = 0;
  initial for (int i = 0; i < 1024; i++) sh[i] = '0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn) begin
      if (rd0_rvalid) begin
        rv0_cnt++;
        if (q0.size() == 0) chk("rd0_spurious_rvalid", 1, 0);
        else begin
          e = q0.pop_front();
          chk("rd0_rdata", rd0_rdata, e.d);
          chk("rd0_latency", cyc - e.cyc, 2);
        end
      end else chk("rd0_rdata_idle", rd0_rdata, 0);
      if (rd1_rvalid) begin
        rv1_cnt++;
        if (q1.size() == 0) chk("rd1_spurious_rvalid", 1, 0);
        else begin
          e = q1.pop_front();
          chk("rd1_rdata", rd1_rdata, e.d);
          chk("rd1_latency", cyc - e.cyc, 2);
        end
      end else chk("rd1_rdata_idle", rd1_rdata, 0);
      if (rd0_valid && rd0_ready) begin
        q0.push_back('{d: sh[rd0_addr], cyc: cyc});
        chk("rd0_enarden", a_en, 1);
        chk("rd0_araddr", a_addr, {rd0_addr, 4'b0000});
      end
      if (rd1_valid && rd1_ready) begin
        q1.push_back('{d: sh[rd1_addr], cyc: cyc});
        chk("rd1_enarden", a_en, 1);
        chk("rd1_araddr", a_addr, {rd1_addr, 4'b0000});
      end
      if (wr_valid && wr_ready) begin
        chk("wr_enbwren", b_en, 1);
        chk("wr_webwe", b_we, 4'b0011);
        chk("wr_bwaddr", b_addr, {wr_addr, 4'b0000});
        chk("wr_din", {dinp, din}, wr_data);
        sh[wr_addr] = wr_data;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    int n;
    rstn = 1'b0;
    q0.delete();
    q1.delete();
`ifdef BRAM18_ARB_INIT_CLEAR_EN
    for (int i = 0; i < 1024; i++) sh[i] = '0;
`endif
    @(posedge clk); #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_rd0_ready", rd0_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_enarden", a_en, 0);
    chk("rst_enbwren", b_en, 0);
    chk("rst_webwe", b_we, 0);
    chk("rst_regce", regce, 0);
    chk("rst_rvalid", {rd0_rvalid, rd1_rvalid}, 0);
    rstn = 1'b1;
    n = 0;
    while (!init_done && n < 2000) begin @(posedge clk); #1; n++; end
`ifdef BRAM18_ARB_INIT_CLEAR_EN
    chk("init_done_cycles", n, 1025);
`else
    chk("init_done_cycles", n, 1);
`endif
  endtask

  task automatic wr(input logic [9:0] a, input logic [17:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    chk("wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int c, input logic [9:0] a);
    int   n = 0;
    logic got;
    if (c == 0) begin rd0_valid = 1'b1; rd0_addr = a; end
    else        begin rd1_valid = 1'b1; rd1_addr = a; end
    do begin
      @(negedge clk);
      got = (c == 0) ? rd0_ready : rd1_ready;
      if (!got) begin n++; @(posedge clk); #1; end
    end while (!got && n < 20);
    if (!got) chk("rd_timeout", 0, 1);
    @(posedge clk); #1;
    rd0_valid = 1'b0; rd1_valid = 1'b0;
  endtask

  initial begin
    int before0, before1, i0, i1;
    rd0_valid = 1'b1; wr_valid = 1'b1;
    do_reset();
    rd0_valid = 1'b0; wr_valid = 1'b0;

    // basic write then read, client 0
    wr(10'h010, 18'h2A5A5);
    before0 = rv0_cnt;
    rd(0, 10'h010);
    idle(4);
    chk("t1_rvalid_count", rv0_cnt - before0, 1);
    chk("t1_q0_empty", q0.size(), 0);

    // back-to-back reads give consecutive responses
    wr(10'h000, 18'h1C001); wr(10'h001, 18'h00A02); wr(10'h002, 18'h3F003);
    for (int i = 0; i < 5; i++) begin
      rd0_valid = (i < 3); rd0_addr = 10'(i);
      @(negedge clk);
      if (i < 3) chk("t4_ready", rd0_ready, 1);
      if (i >= 2) chk("t4_b2b_rvalid", rd0_rvalid, 1);
      @(posedge clk); #1;
    end
    idle(3);

    // same-address collision on the top word
    rd1_valid = 1'b1; rd1_addr = 10'h3FF;
    wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 18'h00FFF;
    @(negedge clk);
    chk("t3_collision_rd1_ready", rd1_ready, 0);
    chk("t3_collision_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t3_retry_rd1_ready", rd1_ready, 1);
    @(posedge clk); #1;
    rd1_valid = 1'b0;
    idle(4);
    chk("t3_q1_empty", q1.size(), 0);

    for (int i = 1; i <= 8; i++) wr(10'(i), 18'h10000 + 18'(i * 18'h111));

    // reset with a read in flight
    before1 = rv1_cnt;
    rd(1, 10'h005);
    do_reset();
    idle(4);
    chk("t5_dropped_rvalid", rv1_cnt - before1, 0);

    // both clients streaming: 0,1,0,1 starting from client 0 after reset
    before0 = rv0_cnt; before1 = rv1_cnt;
    i0 = 0; i1 = 0;
    for (int i = 0; i < 8; i++) begin
      rd0_valid = 1'b1; rd0_addr = 10'(1 + 2 * i0);
      rd1_valid = 1'b1; rd1_addr = 10'(2 + 2 * i1);
      @(negedge clk);
      chk("t2_grant0", rd0_ready, (i % 2 == 0));
      chk("t2_grant1", rd1_ready, (i % 2 == 1));
      if (rd0_ready) i0++;
      if (rd1_ready) i1++;
      @(posedge clk); #1;
    end
    rd0_valid = 1'b0; rd1_valid = 1'b0;
    idle(4);
    chk("t2_rvalid0_count", rv0_cnt - before0, 4);
    chk("t2_rvalid1_count", rv1_cnt - before1, 4);

    // untouched word reads as zero
    before0 = rv0_cnt;
    rd(0, 10'h200);
    idle(4);
    chk("t6_rvalid_count", rv0_cnt - before0, 1);
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
